if_fetch_unit: RTL and testbench

//  Instruction-fetch stage that produces the 32-bit `ins` word consumed by the controller/decoder in ID.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_fetch_unit_if.sv | 11 +
 rtl/if_fetch_unit_next_pc.sv | 29 ++
 rtl/if_fetch_unit.sv | 106 ++++++++++
 tb/tb_if_fetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: instruction/PC constants and
// the fetch state encoding.
package mips_pkg;

    localparam int          PC_W    = 32;
    localparam logic [31:0] NOP_INS = 32'h0000_0000;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Jump/branch targets are word addresses; the low two bits never reach the PC.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and a synchronous
// ROM (slave) that returns data one cycle after the address is presented.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 10
) ();
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit_next_pc.sv
// Next fetch-PC selection: sequential +4, redirect target, or hold.
module if_next_pc
    import mips_pkg::*;
(
    input  fetch_state_t      state,
    input  logic [PC_W-1:0]   fpc,
    input  logic              stall,
    input  logic              redirect,
    input  logic              halt,
    input  logic [PC_W-1:0]   target,
    output logic [PC_W-1:0]   fpc_next
);

    always_comb begin
        fpc_next = fpc;
        if (state != HALT) begin
            // A halt still lets fpc step past the current fetch so a resume
            // restarts at the instruction following it (or at the redirect target).
            if (halt) begin
                fpc_next = redirect ? word_align(target) : fpc + 32'd4;
            end else if (redirect) begin
                fpc_next = word_align(target);
            end else if (state == FILL || !stall) begin
                fpc_next = fpc + 32'd4;
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency ROM and
// applies stall, redirect/kill and halt/resume controls toward ID.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          ADDR_W   = 10,
    parameter int          CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_target_i,
    input  logic                 halt_i,
    input  logic                 resume_i,
    if_fetch_unit_if.master      imem,
    output logic [31:0]          ins_o,
    output logic [31:0]          pc_o,
    output logic [31:0]          pc4_o,
    output logic                 ins_valid_o,
    output logic                 halted_o,
    output logic [CNT_W-1:0]     fetch_cnt_o
);

    fetch_state_t      state;
    logic [PC_W-1:0]   fpc;
    logic [PC_W-1:0]   fpc_next;
    logic [PC_W-1:0]   pc_d1;
    logic              inflight;
    logic              halted_q;
    logic [CNT_W-1:0]  fetch_cnt;
    logic              use_buf;
    logic [31:0]       ins_buf;
    logic [31:0]       ins_sel;
    logic              hold;
    logic              accept;

    if_next_pc u_next_pc (
        .state    (state),
        .fpc      (fpc),
        .stall    (stall_i),
        .redirect (redirect_i),
        .halt     (halt_i),
        .target   (redirect_target_i),
        .fpc_next (fpc_next)
    );

    // Only a RUN-state stall with no higher-priority event freezes the stage.
    assign hold   = (state == RUN) && stall_i && !redirect_i && !halt_i;
    assign accept = inflight && !stall_i && !redirect_i && !halt_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            fpc       <= PC_RESET;
            pc_d1     <= PC_RESET;
            inflight  <= 1'b0;
            halted_q  <= 1'b0;
            fetch_cnt <= '0;
            use_buf   <= 1'b0;
        end else begin
            fpc     <= fpc_next;
            use_buf <= hold;
            if (accept) fetch_cnt <= fetch_cnt + CNT_W'(1);
            unique case (state)
                HALT: begin
                    if (resume_i) begin
                        state    <= FILL;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    if (halt_i) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                        inflight <= 1'b0;
                    end else if (redirect_i) begin
                        state    <= RUN;
                        inflight <= 1'b0;
                    end else if (!hold) begin
                        state    <= RUN;
                        inflight <= 1'b1;
                        pc_d1    <= fpc;
                    end
                end
            endcase
        end
    end

    // The ROM keeps reading fpc while stalled, so the word shown to ID is
    // parked here for the duration of the stall.
    always_ff @(posedge clk) begin
        if (hold) ins_buf <= ins_sel;
    end

    assign ins_sel        = use_buf ? ins_buf : imem.imem_rdata;
    assign ins_o          = inflight ? ins_sel : NOP_INS;
    assign ins_valid_o    = inflight;
    assign pc_o           = pc_d1;
    assign pc4_o          = pc_d1 + 32'd4;
    assign halted_o       = halted_q;
    assign fetch_cnt_o    = fetch_cnt;
    assign imem.imem_addr = fpc[ADDR_W+1:2];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run, with a
// 1024-word and a 16-word instance sharing the same control inputs.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall_i, redirect_i, halt_i, resume_i;
    logic [31:0] tgt;

    logic [31:0] ins_a, pc_a, pc4_a, cnt_a;
    logic        vld_a, hlt_a;
    logic [31:0] ins_b, pc_b, pc4_b, cnt_b;
    logic        vld_b, hlt_b;

    logic [31:0] rom_a [1024];
    logic [31:0] rom_b [16];

    int checks = 0;
    int errors = 0;

    // Reference model: what the decoder should see and where fetch is heading.
    bit          m_halt, m_fill, m_vld;
    logic [31:0] m_next, m_pc, m_cnt;

    always #5 clk = ~clk;

    if_fetch_unit_if #(.ADDR_W(10)) imem_a ();
    if_fetch_unit_if #(.ADDR_W(4))  imem_b ();

    always_ff @(posedge clk) imem_a.imem_rdata <= rom_a[imem_a.imem_addr];
    always_ff @(posedge clk) imem_b.imem_rdata <= rom_b[imem_b.imem_addr];

    if_fetch_unit #(.PC_RESET(32'h0), .ADDR_W(10), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_target_i(tgt), .halt_i(halt_i), .resume_i(resume_i), .imem(imem_a),
        .ins_o(ins_a), .pc_o(pc_a), .pc4_o(pc4_a), .ins_valid_o(vld_a),
        .halted_o(hlt_a), .fetch_cnt_o(cnt_a)
    );

    if_fetch_unit #(.PC_RESET(32'h0), .ADDR_W(4), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_target_i(tgt), .halt_i(halt_i), .resume_i(resume_i), .imem(imem_b),
        .ins_o(ins_b), .pc_o(pc_b), .pc4_o(pc4_b), .ins_valid_o(vld_b),
        .halted_o(hlt_b), .fetch_cnt_o(cnt_b)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] pc, input int aw);
        return ((pc >> 2) & ((32'd1 << aw) - 32'd1)) + 32'h100;
    endfunction

    // One clock: drive inputs, advance the model at the edge, return at the falling edge.
    task automatic step(input logic s, input logic r, input logic [31:0] t,
                        input logic h, input logic res, input logic rn);
        stall_i = s; redirect_i = r; tgt = t; halt_i = h; resume_i = res; rst_n = rn;
        @(posedge clk);
        if (!rn) begin
            m_halt = 0; m_fill = 1; m_vld = 0; m_next = 32'h0; m_pc = 32'h0; m_cnt = 0;
        end else begin
            if (m_vld && !s && !r && !h) m_cnt = m_cnt + 1;
            if (m_halt) begin
                if (res) begin m_halt = 0; m_fill = 1; end
            end else if (h) begin
                m_halt = 1; m_vld = 0; m_fill = 0;
                m_next = r ? (t & ~32'h3) : m_next + 32'd4;
            end else if (r) begin
                m_vld = 0; m_fill = 0; m_next = t & ~32'h3;
            end else if (!(s && !m_fill)) begin
                m_vld = 1; m_fill = 0; m_pc = m_next; m_next = m_next + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++; if (ins_a !== 32'h0) begin errors++; $display("FAIL reset_ins got %h exp %h", ins_a, 32'h0); end
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", vld_a); end
        checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc_a); end
        checks++; if (pc4_a !== 32'h4) begin errors++; $display("FAIL reset_pc4 got %h exp 4", pc4_a); end
        checks++; if (hlt_a !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", hlt_a); end
        checks++; if (cnt_a !== 32'h0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_a); end
        checks++; if (imem_a.imem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", imem_a.imem_addr); end
    endtask

    task automatic test_fill_run();
        step(0, 0, 0, 0, 0, 1);
        checks++; if (ins_a !== 32'h100 || pc_a !== 32'h0 || vld_a !== 1'b1) begin errors++;
            $display("FAIL fill_first got ins %h pc %h vld %b exp 100/0/1", ins_a, pc_a, vld_a); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (ins_a !== 32'h101 || pc_a !== 32'h4) begin errors++;
            $display("FAIL run_second got ins %h pc %h exp 101/4", ins_a, pc_a); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (ins_a !== 32'h102 || pc_a !== 32'h8 || pc4_a !== 32'hC || cnt_a !== 32'd2) begin errors++;
            $display("FAIL run_third got ins %h pc %h pc4 %h cnt %0d exp 102/8/c/2", ins_a, pc_a, pc4_a, cnt_a); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 1);
            checks++; if (ins_a !== 32'h102 || pc_a !== 32'h8 || imem_a.imem_addr !== 10'd3 || cnt_a !== 32'd2) begin errors++;
                $display("FAIL stall_hold%0d got ins %h pc %h addr %0d cnt %0d exp 102/8/3/2", i, ins_a, pc_a, imem_a.imem_addr, cnt_a); end
        end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (ins_a !== 32'h103 || pc_a !== 32'hC || cnt_a !== 32'd3) begin errors++;
            $display("FAIL stall_release got ins %h pc %h cnt %0d exp 103/c/3", ins_a, pc_a, cnt_a); end
    endtask

    task automatic test_redirect();
        step(0, 0, 0, 0, 0, 1);
        checks++; if (pc_a !== 32'h10 || cnt_a !== 32'd4) begin errors++;
            $display("FAIL redir_pre got pc %h cnt %0d exp 10/4", pc_a, cnt_a); end
        step(0, 1, 32'h43, 0, 0, 1);
        checks++; if (ins_a !== 32'h0 || vld_a !== 1'b0 || imem_a.imem_addr !== 10'd16 || cnt_a !== 32'd4) begin errors++;
            $display("FAIL redir_kill got ins %h vld %b addr %0d cnt %0d exp 0/0/16/4", ins_a, vld_a, imem_a.imem_addr, cnt_a); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (ins_a !== 32'h110 || pc_a !== 32'h40 || vld_a !== 1'b1 || ins_b !== 32'h100) begin errors++;
            $display("FAIL redir_target got ins %h pc %h vld %b insb %h exp 110/40/1/100", ins_a, pc_a, vld_a, ins_b); end
    endtask

    task automatic test_redirect_stall();
        step(1, 1, 32'h200, 0, 0, 1);
        checks++; if (vld_a !== 1'b0 || imem_a.imem_addr !== 10'h80 || cnt_a !== 32'd4) begin errors++;
            $display("FAIL redir_stall_kill got vld %b addr %h cnt %0d exp 0/80/4", vld_a, imem_a.imem_addr, cnt_a); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (ins_a !== 32'h180 || pc_a !== 32'h200) begin errors++;
            $display("FAIL redir_stall_target got ins %h pc %h exp 180/200", ins_a, pc_a); end
    endtask

    task automatic test_halt_resume();
        step(0, 1, 32'h80, 1, 0, 1);
        checks++; if (hlt_a !== 1'b1 || vld_a !== 1'b0 || ins_a !== 32'h0 || imem_a.imem_addr !== 10'h20 || cnt_a !== 32'd4) begin errors++;
            $display("FAIL halt_enter got hlt %b vld %b ins %h addr %h cnt %0d exp 1/0/0/20/4", hlt_a, vld_a, ins_a, imem_a.imem_addr, cnt_a); end
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 32'h300, 0, 0, 1);
            checks++; if (hlt_a !== 1'b1 || imem_a.imem_addr !== 10'h20 || pc_a !== 32'h200 || vld_a !== 1'b0) begin errors++;
                $display("FAIL halt_hold%0d got hlt %b addr %h pc %h vld %b exp 1/20/200/0", i, hlt_a, imem_a.imem_addr, pc_a, vld_a); end
        end
        step(0, 0, 0, 0, 1, 1);
        checks++; if (hlt_a !== 1'b0 || vld_a !== 1'b0) begin errors++;
            $display("FAIL resume_fill got hlt %b vld %b exp 0/0", hlt_a, vld_a); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (ins_a !== 32'h120 || pc_a !== 32'h80 || ins_b !== 32'h100 || vld_a !== 1'b1) begin errors++;
            $display("FAIL resume_first got ins %h pc %h insb %h vld %b exp 120/80/100/1", ins_a, pc_a, ins_b, vld_a); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (pc_a !== 32'h84 || cnt_a !== 32'd5) begin errors++;
            $display("FAIL resume_next got pc %h cnt %0d exp 84/5", pc_a, cnt_a); end
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 1);
        checks++; if (pc_b !== 32'h3C || imem_b.imem_addr !== 4'd0 || ins_b !== 32'h10F) begin errors++;
            $display("FAIL wrap_addr got pc %h addr %0d ins %h exp 3c/0/10f", pc_b, imem_b.imem_addr, ins_b); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (pc_b !== 32'h40 || ins_b !== 32'h100 || ins_a !== 32'h110) begin errors++;
            $display("FAIL wrap_data got pc %h insb %h insa %h exp 40/100/110", pc_b, ins_b, ins_a); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 1, 0, 1);
        checks++; if (hlt_a !== 1'b1) begin errors++; $display("FAIL mid_halt got %b exp 1", hlt_a); end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (hlt_a !== 1'b0 || vld_a !== 1'b0 || ins_a !== 32'h0 || pc_a !== 32'h0 || cnt_a !== 32'h0) begin errors++;
            $display("FAIL rst_in_halt got hlt %b vld %b ins %h pc %h cnt %0d exp 0/0/0/0/0", hlt_a, vld_a, ins_a, pc_a, cnt_a); end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        checks++; if (vld_a !== 1'b0 || ins_a !== 32'h0 || pc_a !== 32'h0 || cnt_a !== 32'h0 || imem_a.imem_addr !== 10'd0) begin errors++;
            $display("FAIL rst_in_stall got vld %b ins %h pc %h cnt %0d addr %0d exp 0/0/0/0/0", vld_a, ins_a, pc_a, cnt_a, imem_a.imem_addr); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (ins_a !== 32'h100 || pc_a !== 32'h0) begin errors++;
            $display("FAIL rst_in_stall_restart got ins %h pc %h exp 100/0", ins_a, pc_a); end
    endtask

    task automatic test_random();
        logic s, r, h, res, rn;
        logic [31:0] t, e_a, e_b;
        for (int i = 0; i < 400; i++) begin
            rn  = ($urandom_range(0, 79) != 0);
            s   = ($urandom_range(0, 2) == 0);
            r   = ($urandom_range(0, 5) == 0);
            t   = $urandom();
            h   = !m_halt && ($urandom_range(0, 29) == 0);
            res = m_halt && ($urandom_range(0, 2) == 0);
            step(s, r, t, h, res, rn);
            e_a = m_vld ? rom_word(m_pc, 10) : 32'h0;
            e_b = m_vld ? rom_word(m_pc, 4) : 32'h0;
            checks++; if (ins_a !== e_a) begin errors++; $display("FAIL rnd_ins_a cyc %0d got %h exp %h", i, ins_a, e_a); end
            checks++; if (ins_b !== e_b) begin errors++; $display("FAIL rnd_ins_b cyc %0d got %h exp %h", i, ins_b, e_b); end
            checks++; if (vld_a !== m_vld || vld_b !== m_vld) begin errors++; $display("FAIL rnd_vld cyc %0d got %b/%b exp %b", i, vld_a, vld_b, m_vld); end
            checks++; if (pc_a !== m_pc || pc4_a !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc cyc %0d got %h/%h exp %h", i, pc_a, pc4_a, m_pc); end
            checks++; if (hlt_a !== m_halt || hlt_b !== m_halt) begin errors++; $display("FAIL rnd_halted cyc %0d got %b/%b exp %b", i, hlt_a, hlt_b, m_halt); end
            checks++; if (cnt_a !== m_cnt || cnt_b !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d", i, cnt_a, cnt_b, m_cnt); end
            checks++; if (imem_a.imem_addr !== m_next[11:2] || imem_b.imem_addr !== m_next[5:2]) begin errors++;
                $display("FAIL rnd_addr cyc %0d got %h/%h exp %h", i, imem_a.imem_addr, imem_b.imem_addr, m_next[11:2]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_a[i] = 32'h100 + i;
        for (int i = 0; i < 16; i++)   rom_b[i] = 32'h100 + i;
        test_reset();
        test_fill_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt_resume();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
